// File: rtl/serializador_idle_pkg.sv
// Shared constants and state encoding for the serializer and its phase counter.
// The receive-side paralelizador imports the same package.
package serializador_idle_pkg;

  localparam int         WIDTH     = 8;
  localparam logic [7:0] IDLE_CHAR = 8'hBC;  // K28.5 comma

  // Phase at which a new byte is loaded, and the phase one cycle before it.
  localparam logic [2:0] PHASE_LAST    = 3'd7;
  localparam logic [2:0] PHASE_PRELOAD = 3'd6;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/serializador_idle_contador_fase.sv
// 3-bit bit-phase counter that wraps every byte slot.
// load_edge marks the final phase, where the next edge starts a new slot.
module contador_fase
  import serializador_idle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] cnt,
  output logic       load_edge
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 3'd1;
  end

  // Resetting to the last phase makes the first edge after release a load edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= PHASE_LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign load_edge = (cnt_q == PHASE_LAST);

endmodule

// File: rtl/serializador_idle.sv
// Byte-to-serial transmit stage on clk8f: comma preamble after reset, then
// MSB-first payload bytes with K28.5 filling every slot that has no data.
module serializador_idle #(
  parameter int         WIDTH      = serializador_idle_pkg::WIDTH,
  parameter logic [7:0] IDLE_CHAR  = serializador_idle_pkg::IDLE_CHAR,
  parameter int         SYNC_BYTES = 4
) (
  input  logic             clk8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             byte_start,
  output logic             payload,
  output logic             active
);

  import serializador_idle_pkg::*;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES);

  generate
    if (WIDTH != 8 || SYNC_BYTES < 1 || SYNC_BYTES > 15) begin : g_bad_params
      $error("serializador_idle: WIDTH must be 8 and SYNC_BYTES in 1..15");
    end
  endgenerate

  logic [2:0] cnt;
  logic       load_edge;

  state_e     state_q,      state_d;
  logic [7:0] sh_q,         sh_d;
  logic [3:0] scnt_q,       scnt_d;
  logic       byte_start_q, byte_start_d;
  logic       payload_q,    payload_d;
  logic       ready_q,      ready_d;

  contador_fase u_fase (
    .clk       (clk8f),
    .rst       (reset),
    .cnt       (cnt),
    .load_edge (load_edge)
  );

  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    sh_d         = {sh_q[6:0], 1'b0};
    byte_start_d = 1'b0;
    payload_d    = payload_q;

    if (load_edge) begin
      byte_start_d = 1'b1;
      if (state_q == SYNC) begin
        sh_d      = IDLE_CHAR;
        payload_d = 1'b0;
        scnt_d    = scnt_q + 4'd1;
        if (scnt_q + 4'd1 == SYNC_LAST) begin
          state_d = ACTIVE;
        end
      end else if (valid_in && ready_q) begin
        sh_d      = data_in;
        payload_d = 1'b1;
      end else begin
        // No byte offered: fill the slot with a comma, which is not an error.
        sh_d      = IDLE_CHAR;
        payload_d = 1'b0;
      end
    end

    // Registered ready: it anticipates the next cycle being a load edge in ACTIVE.
    ready_d = (state_d == ACTIVE) && (cnt == PHASE_PRELOAD);
  end

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      sh_q         <= 8'h00;
      scnt_q       <= 4'd0;
      byte_start_q <= 1'b0;
      payload_q    <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      scnt_q       <= scnt_d;
      byte_start_q <= byte_start_d;
      payload_q    <= payload_d;
      ready_q      <= ready_d;
    end
  end

  assign data_out   = sh_q[7];
  assign byte_start = byte_start_q;
  assign payload    = payload_q;
  assign ready_out  = ready_q;
  assign active     = (state_q == ACTIVE);

endmodule

// File: doc/serializador_idle.md
Name: serializador_idle

Overview:
- Parallel-to-serial transmit stage that sits directly downstream of the clock generator.
- Runs on the fastest generated clock, clk8f, with an internal 3-bit bit-phase counter: one byte slot is 8 clk8f cycles, which is one clkf period.
- Sends 8-bit payload bytes MSB first.
- Fills every slot that has no payload with the idle/comma character 0xBC (K28.5).
- After reset, sends a fixed preamble of comma bytes before it accepts any data.

Parameters:
- WIDTH, 8, parallel byte width; only 8 is supported.
- IDLE_CHAR, 8'hBC, byte sent in sync and idle slots.
- SYNC_BYTES, 4, number of comma bytes sent after reset before payload is accepted; legal range 1..15.

Ports:
- clk8f  input  1  serial bit clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  payload byte.
- valid_in  input  1  data_in holds a valid byte.
- ready_out  output  1  stage will take data_in on this edge if valid_in is high.
- data_out  output  1  serial bit stream, MSB first.
- byte_start  output  1  high during bit 7 (the first bit) of every slot.
- payload  output  1  high for all 8 bits of a payload slot; low for idle/comma slots.
- active  output  1  sync preamble is complete.

Behaviour:
- Internal state:
  - shift register sh[7:0]; data_out = sh[7].
  - phase counter cnt, 0..7.
  - sync byte counter scnt.
  - state: SYNC or ACTIVE.
- Reset (asynchronous, takes effect immediately):
  - sh=0, cnt=7, scnt=0, state=SYNC.
  - data_out=0, byte_start=0, payload=0, ready_out=0, active=0.
- Every rising edge where cnt==7 is a load edge:
  - sh <= next byte; cnt <= 0.
  - byte_start <= 1 for exactly one cycle.
  - payload <= 1 if the loaded byte is data, else 0.
- Every other edge:
  - sh <= sh << 1 (LSB filled with 0); cnt <= cnt+1; byte_start <= 0.
- Next-byte selection on a load edge:
  - state SYNC: load IDLE_CHAR and increment scnt. When this load brings scnt to SYNC_BYTES, state becomes ACTIVE and active goes to 1 on that edge.
  - state ACTIVE with valid_in && ready_out: load data_in. This is a handshake transfer.
  - state ACTIVE otherwise: load IDLE_CHAR with payload=0. Idle insertion happens with no error.
- ready_out:
  - High exactly in cycles where state==ACTIVE and cnt==7, so at most one transfer per 8 cycles.
  - Must be a registered output; no combinational path from valid_in.
- Upstream has no buffering. When valid_in is high while ready_out is low, the byte is not consumed and upstream must hold it.
- Latency: the MSB of an accepted byte is on data_out in the cycle right after the transfer edge. Its LSB is on data_out 7 cycles later.
- First edge after reset release is always a load edge (cnt was 7), so the preamble starts immediately.
- If valid_in rises during the SYNC load edge that completes the preamble, it is ignored, because ready_out was still 0. The first payload slot is slot SYNC_BYTES+1.
- Reset asserted mid-byte aborts the byte. The preamble restarts from scnt=0 after release, and the aborted byte is never resent.
- scnt saturates at SYNC_BYTES in state ACTIVE. state never returns to SYNC except by reset.

Decomposition:
- Shared package/include holds:
  - IDLE_CHAR (K28.5 = 8'hBC);
  - state encoding SYNC=1'b0, ACTIVE=1'b1;
  - WIDTH.
- One sub-module is natural: contador_fase (3-bit wrap counter with a load_edge output, cnt==7). It is reused by the matching receive-side paralelizador.
- Everything else stays in the top module.

Test Plan:
- Reset release with valid_in=0 and SYNC_BYTES=4:
  - data_out carries 10111100 repeated 4 times (32 cycles), byte_start pulses every 8 cycles, payload=0.
  - active rises on the 4th load edge; ready_out first goes high in cycle 31 after release.
- After sync, present data_in=0xA5 with valid_in held high: transfer at the first ready_out cycle, then data_out=1,0,1,0,0,1,0,1 with payload=1 for those 8 cycles.
- Back-to-back valid bytes 0x00, 0xFF, 0x3C: each is transferred exactly once at consecutive ready_out pulses, 8 cycles apart, with no idle slot between them.
- valid_in raised at cnt=3 with 0x81: it waits with ready_out=0, is taken at the next cnt==7 cycle, and the current slot finishes unchanged.
- valid_in dropped after one byte: the next slot is 0xBC with payload=0, and active stays 1.
- Reset pulse at cnt=4 of a payload byte: all outputs are 0 asynchronously, and after release the full 4-byte 0xBC preamble repeats before ready_out returns.
